// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter feeding one registered per-bit gate evaluator.
// Optional macro ILLEGAL_OP_FLAG_EN adds an s_err output that flags opcode 3'b111.
module gate_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      s,
  output logic                  s_valid,
  output logic [IDW-1:0]        s_id,
  input  logic                  s_ready
`ifdef ILLEGAL_OP_FLAG_EN
  ,
  output logic                  s_err
`endif
);

  localparam int OPW = 3;
  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDW-1:0]   last_r;
  logic [IDW-1:0]   capIdx_r;
  logic [OPW-1:0]   capOp_r;
  logic [WIDTH-1:0] capA_r;
  logic [WIDTH-1:0] capB_r;
  logic [IDW-1:0]   winner_s;
  logic             found_s;
  logic [OPW-1:0]   selOp_s;
  logic [WIDTH-1:0] selA_s;
  logic [WIDTH-1:0] selB_s;

  function automatic logic [WIDTH-1:0] gateEval(input logic [2:0] opc,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (opc)
      3'b000:  r = ~(x & y);
      3'b001:  r = ~(x | y);
      3'b010:  r = x & y;
      3'b011:  r = x | y;
      3'b100:  r = ~x;
      3'b101:  r = x ^ y;
      3'b110:  r = ~(x ^ y);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Round-robin search: first set request strictly after the last winner, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    found_s  = 1'b0;
    winner_s = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand     = IDW'((int'(last_r) + k) % NREQ);
      winner_s = (!found_s && req[cand]) ? cand : winner_s;
      found_s  = found_s | req[cand];
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    selOp_s = {OPW{1'b0}};
    selA_s  = {WIDTH{1'b0}};
    selB_s  = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      selOp_s = (winner_s == IDW'(i)) ? op[OPW*i +: OPW]     : selOp_s;
      selA_s  = (winner_s == IDW'(i)) ? a[WIDTH*i +: WIDTH]  : selA_s;
      selB_s  = (winner_s == IDW'(i)) ? b[WIDTH*i +: WIDTH]  : selB_s;
    end
  end

  // Arbitrate / evaluate / hold FSM with registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      last_r   <= IDW'(NREQ - 1);
      capIdx_r <= {IDW{1'b0}};
      capOp_r  <= {OPW{1'b0}};
      capA_r   <= {WIDTH{1'b0}};
      capB_r   <= {WIDTH{1'b0}};
      gnt      <= {NREQ{1'b0}};
      s        <= {WIDTH{1'b0}};
      s_valid  <= 1'b0;
      s_id     <= {IDW{1'b0}};
`ifdef ILLEGAL_OP_FLAG_EN
      s_err    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            capOp_r  <= selOp_s;
            capA_r   <= selA_s;
            capB_r   <= selB_s;
            capIdx_r <= winner_s;
            last_r   <= winner_s;
            gnt      <= GNT_ONE << winner_s;
            state_r  <= EXEC;
          end else begin
            gnt <= {NREQ{1'b0}};
          end
        end
        EXEC: begin
          gnt     <= {NREQ{1'b0}};
          s       <= gateEval(capOp_r, capA_r, capB_r);
          s_id    <= capIdx_r;
          s_valid <= 1'b1;
`ifdef ILLEGAL_OP_FLAG_EN
          s_err   <= (capOp_r == 3'b111);
`endif
          state_r <= HOLD;
        end
        HOLD: begin
          if (s_ready) begin
            s_valid <= 1'b0;
            state_r <= IDLE;
          end else begin
            s_valid <= 1'b1;
          end
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          s_valid <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: directed scenarios plus randomized traffic
// checked against a bit-arithmetic gate model and a round-robin pick model.
module tb_gate_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] a;
  logic [WIDTH*NREQ-1:0] b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      s;
  logic                  s_valid;
  logic [IDW-1:0]        s_id;
  logic                  s_ready;
`ifdef ILLEGAL_OP_FLAG_EN
  logic                  s_err;
`endif

  int checks;
  int errors;
  int lastM;

  gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .s(s), .s_valid(s_valid), .s_id(s_id), .s_ready(s_ready)
`ifdef ILLEGAL_OP_FLAG_EN
    , .s_err(s_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-bit reference using plain 0/1 arithmetic.
  function automatic logic [WIDTH-1:0] gate_ref(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    int p, q, v;
    for (int j = 0; j < WIDTH; j++) begin
      p = int'(x[j]);
      q = int'(y[j]);
      case (int'(o))
        0:       v = 1 - p * q;
        1:       v = 1 - (p + q - p * q);
        2:       v = p * q;
        3:       v = p + q - p * q;
        4:       v = 1 - p;
        5:       v = (p + q) % 2;
        6:       v = 1 - (p + q) % 2;
        default: v = 0;
      endcase
      r[j] = (v != 0);
    end
    return r;
  endfunction

  // Round-robin model: nearest requester after the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int d = 1; d <= NREQ; d++) begin
      if (r[(last + d) % NREQ]) return (last + d) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; s_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    lastM = NREQ - 1;
  endtask

  task automatic drain();
    req = '0; s_ready = 1'b1;
    repeat (4) tick();
    s_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", s_valid); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL rst_s got=%h exp=00", s); end
    checks++; if (s_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", s_id); end
    rst_n = 1'b1;
    op = 12'b110_101_011_010; a = 32'h12345678; b = 32'h9ABCDEF0;
    req = 4'b1111; s_ready = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
    req = '0;
    tick();
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_valid got=%b exp=1", s_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", s_valid); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL rst_async_s got=%h exp=00", s); end
    checks++; if (s_id !== 2'd0 || gnt !== 4'b0000) begin errors++; $display("FAIL rst_async_id_gnt got=%0d/%b exp=0/0000", s_id, gnt); end
    tick();
    rst_n = 1'b1; lastM = NREQ - 1;
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_rearm_gnt got=%b exp=0001", gnt); end
    lastM = 0;
    drain();
  endtask

  task automatic test_single();
    do_reset();
    op = {$urandom} % 4096; a = $urandom; b = $urandom;
    op[6 +: 3] = 3'b101; a[16 +: 8] = 8'hF0; b[16 +: 8] = 8'hAA;
    req = 4'b0100; s_ready = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", s_valid); end
    req = '0; lastM = 2;
    tick();
    checks++; if (s !== 8'h5A) begin errors++; $display("FAIL single_s got=%h exp=5a", s); end
    checks++; if (s_id !== 2'd2 || s_valid !== 1'b1) begin errors++; $display("FAIL single_id_valid got=%0d/%b exp=2/1", s_id, s_valid); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
    drain();
  endtask

  task automatic test_round_robin();
    int n, lastCyc, idx;
    logic [NREQ-1:0] one;
    do_reset();
    one = 4'b0001;
    n = 0; lastCyc = -1;
    req = 4'b1111; s_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt != '0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
        lastM = idx;
        if (n < 5) begin
          checks++; if (gnt !== (one << (n % NREQ))) begin errors++; $display("FAIL rr_seq%0d got=%b exp=%b", n, gnt, one << (n % NREQ)); end
          if (n > 0) begin
            checks++; if (c - lastCyc != 3) begin errors++; $display("FAIL rr_spacing%0d got=%0d exp=3", n, c - lastCyc); end
          end
          lastCyc = c;
          n++;
        end
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", n); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g;
    op[0 +: 3] = 3'b000; a[0 +: 8] = 8'hFF; b[0 +: 8] = 8'h0F;
    req = 4'b0001; s_ready = 1'b0;
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL bp_gnt got=%b exp=0001", g); end
    lastM = 0;
    req = 4'b1110;
    tick();
    checks++; if (s_valid !== 1'b1 || s !== 8'hF0) begin errors++; $display("FAIL bp_first got=%b/%h exp=1/f0", s_valid, s); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s !== 8'hF0 || s_valid !== 1'b1 || s_id !== 2'd0 || gnt !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d got=%h/%b/%0d/%b exp=f0/1/0/0000", i, s, s_valid, s_id, gnt);
      end
    end
    s_ready = 1'b1;
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", s_valid); end
    drain();
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] expTab [8];
    logic [NREQ-1:0] g, one;
    int idx;
    expTab = '{8'h77, 8'h11, 8'h88, 8'hEE, 8'h33, 8'h66, 8'h99, 8'h00};
    one = 4'b0001;
    for (int o = 0; o < 8; o++) begin
      idx = $urandom_range(0, NREQ - 1);
      op = {$urandom} % 4096; a = $urandom; b = $urandom;
      op[3*idx +: 3] = 3'(o); a[8*idx +: 8] = 8'hCC; b[8*idx +: 8] = 8'hAA;
      req = one << idx; s_ready = 1'b0;
      wait_gnt(g);
      checks++; if (g !== (one << idx)) begin errors++; $display("FAIL sweep_gnt%0d got=%b exp=%b", o, g, one << idx); end
      lastM = idx; req = '0;
      tick();
      checks++; if (s !== expTab[o] || s_valid !== 1'b1) begin errors++; $display("FAIL sweep_s%0d got=%h/%b exp=%h/1", o, s, s_valid, expTab[o]); end
`ifdef ILLEGAL_OP_FLAG_EN
      checks++; if (s_err !== (o == 7)) begin errors++; $display("FAIL sweep_err%0d got=%b exp=%b", o, s_err, o == 7); end
`endif
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0;
    end
  endtask

  task automatic test_late_joiner();
    logic [NREQ-1:0] g;
    do_reset();
    op = {$urandom} % 4096; a = $urandom; b = $urandom;
    req = 4'b0001; s_ready = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL late_first got=%b exp=0001", gnt); end
    req = 4'b1001;
    wait_gnt(g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL late_second got=%b exp=1000", g); end
    req = 4'b0001;
    wait_gnt(g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL late_third got=%b exp=0001", g); end
    lastM = 0;
    drain();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r, g, one;
    logic [WIDTH-1:0] expS;
    logic [2:0] expOp;
    int w;
    bit rdy, done;
    one = 4'b0001;
    for (int it = 0; it < 60; it++) begin
      op = {$urandom} % 4096; a = $urandom; b = $urandom;
      r = 4'($urandom_range(1, 15));
      req = r; s_ready = 1'b0;
      w = rr_pick(r, lastM);
      expOp = op[3*w +: 3];
      expS = gate_ref(expOp, a[8*w +: 8], b[8*w +: 8]);
      wait_gnt(g);
      checks++; if (g !== (one << w)) begin errors++; $display("FAIL rand_gnt%0d got=%b exp=%b", it, g, one << w); end
      lastM = w;
      req = '0;
      op = {$urandom} % 4096; a = $urandom; b = $urandom;
      tick();
      checks++; if (s_valid !== 1'b1 || s !== expS || s_id !== 2'(w)) begin
        errors++; $display("FAIL rand_res%0d got=%b/%h/%0d exp=1/%h/%0d", it, s_valid, s, s_id, expS, w);
      end
`ifdef ILLEGAL_OP_FLAG_EN
      checks++; if (s_err !== (expOp == 3'b111)) begin errors++; $display("FAIL rand_err%0d got=%b exp=%b", it, s_err, expOp == 3'b111); end
`endif
      done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
        rdy = (c == 11) ? 1'b1 : 1'($urandom_range(0, 1));
        s_ready = rdy;
        tick();
        if (rdy) begin
          checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rand_drop%0d got=%b exp=0", it, s_valid); end
          done = 1'b1;
        end else begin
          checks++; if (s_valid !== 1'b1 || s !== expS || s_id !== 2'(w) || gnt !== 4'b0000) begin
            errors++; $display("FAIL rand_hold%0d got=%b/%h/%0d/%b exp=1/%h/%0d/0000", it, s_valid, s, s_id, gnt, expS, w);
          end
        end
      end
      s_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; lastM = NREQ - 1;
    rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0; s_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_opcode_sweep();
    test_late_joiner();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
